// File: rtl/arb_requester.sv
// Client-side requester for one r/g pair of the grant arbiter: accepts a burst job,
// holds req until granted, counts granted beats, then idles req for a fixed gap.
module arb_requester #(
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 15,
  parameter int GAP     = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [LEN_W-1:0] job_len,
  output logic             req,
  input  logic             gnt,
  output logic             beat,
  output logic             done,
  output logic             timeout,
  output logic             lost_grant,
  output logic             busy
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam int GAP_W  = (GAP > 1) ? $clog2(GAP + 1) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    GAP_ST = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   remaining_q, remaining_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    wait_cnt_d  = wait_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    job_ready   = 1'b0;
    beat        = 1'b0;
    done        = 1'b0;
    timeout     = 1'b0;
    lost_grant  = 1'b0;
    // Pulses and job_ready are suppressed in any reset cycle; reset beats everything.
    if (!reset) begin
      case (state_q)
        IDLE: begin
          job_ready = 1'b1;
          if (job_valid) begin
            if (job_len != '0) begin
              remaining_d = job_len;
              wait_cnt_d  = '0;
              state_d     = REQ;
            end else begin
              done = 1'b1;
            end
          end
        end
        REQ: begin
          if (gnt) begin
            state_d = XFER;
          end else if (wait_cnt_q == WAIT_W'(TIMEOUT - 1)) begin
            timeout    = 1'b1;
            wait_cnt_d = '0;
            state_d    = IDLE;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end
        XFER: begin
          if (gnt) begin
            beat        = 1'b1;
            remaining_d = remaining_q - LEN_W'(1);
            if (remaining_q == LEN_W'(1)) begin
              done      = 1'b1;
              gap_cnt_d = '0;
              state_d   = GAP_ST;
            end
          end else begin
            lost_grant = 1'b1;
            wait_cnt_d = '0;
            state_d    = REQ;
          end
        end
        GAP_ST: begin
          if (gap_cnt_q == GAP_W'(GAP - 1)) begin
            gap_cnt_d = '0;
            state_d   = IDLE;
          end else begin
            gap_cnt_d = gap_cnt_q + GAP_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign req  = !reset && ((state_q == REQ) || (state_q == XFER));
  assign busy = !reset && (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      wait_cnt_q  <= '0;
      gap_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      wait_cnt_q  <= wait_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

endmodule

// File: tb/tb_arb_requester.sv
// Directed scoreboard bench for arb_requester: each step pushes the expected
// output vector {job_ready,req,busy,beat,done,timeout,lost_grant} and pops it mid-cycle.
module tb_arb_requester;

  logic       clk = 1'b0;
  logic       reset;
  logic       job_valid;
  logic       job_ready;
  logic [3:0] job_len;
  logic       req;
  logic       gnt;
  logic       beat;
  logic       done;
  logic       timeout;
  logic       lost_grant;
  logic       busy;

  int checks     = 0;
  int errors     = 0;
  int beat_total = 0;

  logic [6:0] exp_q[$];
  string      tag_q[$];

  // Expected vectors, bit order {job_ready,req,busy,beat,done,timeout,lost_grant}.
  localparam logic [6:0] E_RST   = 7'b0000000;
  localparam logic [6:0] E_IDLE  = 7'b1000000;
  localparam logic [6:0] E_ZERO  = 7'b1000100;
  localparam logic [6:0] E_REQ   = 7'b0110000;
  localparam logic [6:0] E_BEAT  = 7'b0111000;
  localparam logic [6:0] E_LAST  = 7'b0111100;
  localparam logic [6:0] E_LOST  = 7'b0110001;
  localparam logic [6:0] E_TOUT  = 7'b0110010;
  localparam logic [6:0] E_GAP   = 7'b0010000;

  arb_requester #(.LEN_W(4), .TIMEOUT(15), .GAP(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .job_valid  (job_valid),
    .job_ready  (job_ready),
    .job_len    (job_len),
    .req        (req),
    .gnt        (gnt),
    .beat       (beat),
    .done       (done),
    .timeout    (timeout),
    .lost_grant (lost_grant),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Pops one expected vector and compares it with the live outputs.
  task automatic checkOutput();
    logic [6:0] obs;
    logic [6:0] exp;
    string      tag;
    obs = {job_ready, req, busy, beat, done, timeout, lost_grant};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%b expected=entry", obs);
      return;
    end
    exp = exp_q.pop_front();
    tag = tag_q.pop_front();
    if (beat === 1'b1) beat_total++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drives one cycle of inputs, records the expectation, checks at the falling edge.
  task automatic applyStimulus(input string tag, input logic rst, input logic jv,
                               input logic [3:0] len, input logic g,
                               input logic [6:0] exp);
    reset     = rst;
    job_valid = jv;
    job_len   = len;
    gnt       = g;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    job_valid = 1'b0;
    job_len   = 4'd0;
    gnt       = 1'b0;
    @(posedge clk);
    #1;

    // Reset state
    applyStimulus("rst0", 1, 1, 4'd3, 1, E_RST);
    applyStimulus("rst1", 1, 0, 4'd0, 0, E_RST);
    applyStimulus("rst_idle", 0, 0, 4'd0, 0, E_IDLE);

    // Three-beat burst with grant during the first request cycle
    applyStimulus("t1_accept", 0, 1, 4'd3, 0, E_IDLE);
    applyStimulus("t1_req", 0, 0, 4'd0, 1, E_REQ);
    applyStimulus("t1_beat1", 0, 0, 4'd0, 1, E_BEAT);
    applyStimulus("t1_beat2", 0, 0, 4'd0, 1, E_BEAT);
    applyStimulus("t1_beat3", 0, 0, 4'd0, 1, E_LAST);
    applyStimulus("t1_gap", 0, 0, 4'd0, 0, E_GAP);
    applyStimulus("t1_idle", 0, 0, 4'd0, 0, E_IDLE);

    // Starvation: timeout on the 15th request cycle
    applyStimulus("t2_accept", 0, 1, 4'd2, 0, E_IDLE);
    for (int i = 0; i < 14; i++) applyStimulus("t2_wait", 0, 0, 4'd0, 0, E_REQ);
    applyStimulus("t2_timeout", 0, 0, 4'd0, 0, E_TOUT);
    applyStimulus("t2_idle", 0, 0, 4'd0, 0, E_IDLE);

    // Grant lost after two beats, returns three cycles later
    beat_total = 0;
    applyStimulus("t3_accept", 0, 1, 4'd5, 0, E_IDLE);
    applyStimulus("t3_req", 0, 0, 4'd0, 1, E_REQ);
    applyStimulus("t3_beat1", 0, 0, 4'd0, 1, E_BEAT);
    applyStimulus("t3_beat2", 0, 0, 4'd0, 1, E_BEAT);
    applyStimulus("t3_lost", 0, 0, 4'd0, 0, E_LOST);
    applyStimulus("t3_rereq1", 0, 0, 4'd0, 0, E_REQ);
    applyStimulus("t3_rereq2", 0, 0, 4'd0, 1, E_REQ);
    applyStimulus("t3_beat3", 0, 0, 4'd0, 1, E_BEAT);
    applyStimulus("t3_beat4", 0, 0, 4'd0, 1, E_BEAT);
    applyStimulus("t3_beat5", 0, 0, 4'd0, 1, E_LAST);
    applyStimulus("t3_gap", 0, 0, 4'd0, 0, E_GAP);
    applyStimulus("t3_idle", 0, 0, 4'd0, 0, E_IDLE);
    checks++;
    assert (beat_total === 5) else begin
      errors++;
      $error("FAIL t3_beat_total observed=%0d expected=%0d", beat_total, 5);
    end

    // Zero-length job completes in the acceptance cycle
    applyStimulus("t4_zero", 0, 1, 4'd0, 0, E_ZERO);
    applyStimulus("t4_idle", 0, 0, 4'd0, 0, E_IDLE);

    // Reset mid-transfer with four beats outstanding, then a fresh job
    applyStimulus("t5_accept", 0, 1, 4'd6, 0, E_IDLE);
    applyStimulus("t5_req", 0, 0, 4'd0, 1, E_REQ);
    applyStimulus("t5_beat1", 0, 0, 4'd0, 1, E_BEAT);
    applyStimulus("t5_beat2", 0, 0, 4'd0, 1, E_BEAT);
    applyStimulus("t5_reset", 1, 0, 4'd0, 1, E_RST);
    applyStimulus("t5_after", 0, 0, 4'd0, 0, E_IDLE);
    applyStimulus("t5_new_accept", 0, 1, 4'd1, 0, E_IDLE);
    applyStimulus("t5_new_req", 0, 0, 4'd0, 1, E_REQ);
    applyStimulus("t5_new_last", 0, 0, 4'd0, 1, E_LAST);
    applyStimulus("t5_new_gap", 0, 0, 4'd0, 0, E_GAP);
    applyStimulus("t5_new_idle", 0, 0, 4'd0, 0, E_IDLE);

    // job_valid held high through the burst; grant held high through the gap
    applyStimulus("t6_accept", 0, 1, 4'd2, 0, E_IDLE);
    applyStimulus("t6_req", 0, 1, 4'd7, 1, E_REQ);
    applyStimulus("t6_beat1", 0, 1, 4'd7, 1, E_BEAT);
    applyStimulus("t6_beat2", 0, 1, 4'd1, 1, E_LAST);
    applyStimulus("t6_gap", 0, 1, 4'd0, 1, E_GAP);
    applyStimulus("t6_idle_zero", 0, 1, 4'd0, 1, E_ZERO);
    applyStimulus("t6_idle", 0, 0, 4'd0, 0, E_IDLE);

    checks++;
    assert (exp_q.size() === 0) else begin
      errors++;
      $error("FAIL scoreboard_drain observed=%0d expected=%0d", exp_q.size(), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
